// File: rtl/stoch_fixed_gain_mult_mat.sv
// stoch_fixed_gain_mult_mat
//   Multiplies a matrix of stochastic bitstreams by a fixed integer gain.
//   Every element owns a credit counter: an incoming 1 adds GAIN credits and
//   one credit is drained per enabled cycle as an output 1, so the long-run
//   output density is min(1, GAIN*p). Credit beyond the counter range is
//   discarded and latched in a sticky per-element SAT flag.
//
// Ports
//   CLK   rising-edge clock
//   RST   synchronous active-high reset (clears counters, Y, SAT, BUSY)
//   EN    stream-valid strobe; elements advance only when high
//   A     input stochastic bits, [row][col]
//   Y     registered output stochastic bits, [row][col]
//   SAT   sticky per-element saturation flags, [row][col]
//   BUSY  registered OR of all counters being non-zero after the edge
module stoch_fixed_gain_mult_mat #(
    parameter int GAIN      = 2,
    parameter int NUM_ROWS  = 2,
    parameter int NUM_COLS  = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               EN,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  A,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  Y,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  SAT,
    output logic                               BUSY
);

    generate
        if (GAIN < 1 || GAIN > (2 ** CNT_WIDTH) - 1) begin : g_bad_gain
            $error("stoch_fixed_gain_mult_mat: GAIN out of range 1..2^CNT_WIDTH-1");
        end
        if (NUM_ROWS < 1 || NUM_COLS < 1) begin : g_bad_dims
            $error("stoch_fixed_gain_mult_mat: NUM_ROWS and NUM_COLS must be >= 1");
        end
    endgenerate

    // One extra bit of headroom so counter + GAIN never wraps.
    localparam logic [CNT_WIDTH:0] GAIN_W = (CNT_WIDTH + 1)'(GAIN);
    localparam logic [CNT_WIDTH:0] CMAX_W = {1'b0, {CNT_WIDTH{1'b1}}};

    logic [CNT_WIDTH-1:0]              cnt     [NUM_ROWS][NUM_COLS];
    logic [CNT_WIDTH-1:0]              cnt_nxt [NUM_ROWS][NUM_COLS];
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] y_nxt;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] sat_nxt;
    logic                              busy_nxt;

    always_comb begin
        logic [CNT_WIDTH:0] sum;
        logic [CNT_WIDTH:0] d;
        logic               nz;
        sum      = '0;
        d        = '0;
        nz       = 1'b0;
        cnt_nxt  = cnt;
        y_nxt    = Y;
        sat_nxt  = SAT;
        busy_nxt = 1'b0;
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            for (int unsigned j = 0; j < NUM_COLS; j++) begin
                if (EN) begin
                    // Credit is added before the drain: at most one output 1 per cycle.
                    sum         = {1'b0, cnt[i][j]} + (A[i][j] ? GAIN_W : '0);
                    nz          = (sum != '0);
                    d           = sum - {{CNT_WIDTH{1'b0}}, nz};
                    y_nxt[i][j] = nz;
                    if (d > CMAX_W) begin
                        cnt_nxt[i][j] = CMAX_W[CNT_WIDTH-1:0];
                        sat_nxt[i][j] = 1'b1;
                    end else begin
                        cnt_nxt[i][j] = d[CNT_WIDTH-1:0];
                    end
                end
                // BUSY reflects the post-edge counters, also on stalled edges.
                if (cnt_nxt[i][j] != '0) begin
                    busy_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < NUM_ROWS; i++) begin
                for (int unsigned j = 0; j < NUM_COLS; j++) begin
                    cnt[i][j] <= '0;
                end
            end
            Y    <= '0;
            SAT  <= '0;
            BUSY <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            Y    <= y_nxt;
            SAT  <= sat_nxt;
            BUSY <= busy_nxt;
        end
    end

endmodule

// File: doc/stoch_fixed_gain_mult_mat.md
# stoch_fixed_gain_mult_mat

Matrix stochastic-bitstream multiplier by a fixed integer gain, one counter per element. It is the inverse of the fixed-gain divider: each incoming 1 on an element credits GAIN output 1s. Pending credit is drained one output bit per cycle, so the long-run output density is min(1, GAIN·p). It sits after divider stages to restore scale and before stochastic adders or decoders. Credit that cannot be stored saturates and is flagged.

## Interface
Parameters:
- GAIN, 2, integer multiplier; legal range 1 .. 2^CNT_WIDTH−1.
- NUM_ROWS, 2, matrix rows.
- NUM_COLS, 2, matrix columns.
- CNT_WIDTH, 8, width of each element's credit counter.

Ports:
- CLK  input  1  clock; one clock domain, all logic on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- EN  input  1  stream-valid strobe; all elements advance only when EN=1.
- A  input  [NUM_ROWS-1:0][NUM_COLS-1:0]  input stochastic bits.
- Y  output  [NUM_ROWS-1:0][NUM_COLS-1:0]  output stochastic bits, registered.
- SAT  output  [NUM_ROWS-1:0][NUM_COLS-1:0]  per-element sticky saturation flag.
- BUSY  output  1  OR-reduction of all counters ≠ 0, registered.

## Operation
- Every element (i,j) runs independently and identically. Each has a counter c of CNT_WIDTH bits, CMAX = 2^CNT_WIDTH−1.
- Arithmetic width is CNT_WIDTH+1 bits, so nothing wraps.
- When EN=1, per element:
  - sum = c + (A[i][j] ? GAIN : 0)
  - Y[i][j] ← (sum ≠ 0)
  - d = sum − (sum ≠ 0)
  - If d > CMAX: c ← CMAX and SAT[i][j] ← 1. Otherwise c ← d.
- When EN=0: c, Y and SAT all hold. A is ignored.
- SAT clears only on RST.
- Credit lost to saturation is discarded and never replayed.
- BUSY ← 1 if any element's next c ≠ 0. It is evaluated on the updated counter values, on every edge, including EN=0 edges.
- GAIN=1: c stays 0 forever, and Y is A delayed one enabled cycle (pure register).
- Simultaneous input 1 and pending credit: the credit is added before the drain, so at most one output bit is emitted per cycle. Excess credit stays queued.
- Per-element state: IDLE (c=0) and DRAIN (c>0). There is no other control FSM.
  - IDLE → DRAIN when A=1 and GAIN≥2.
  - DRAIN → IDLE when c=1 and A=0.
- Parameter checks at elaboration: error if GAIN<1, GAIN>CMAX, NUM_ROWS<1 or NUM_COLS<1.

## Timing
- Latency: an input 1 sampled at enabled edge k produces its first output 1 on Y after edge k.
  - The remaining GAIN−1 ones follow on consecutive enabled edges, if no other credit is queued.
- Throughput: one input bit per element per enabled cycle, with no back-pressure.
- Reset: RST sampled high at an edge sets all c=0, Y=0, SAT=0 and BUSY=0 after that edge. It overrides EN and A.
- Reset mid-drain discards all queued credit. The first post-reset enabled edge behaves as from IDLE.
- SAT asserts after the edge on which the clamp occurs.

## Test plan
- Impulse, GAIN=3, 1×1, EN=1: A=1 for one cycle then 0 → Y=1 after edges k, k+1 and k+2, then 0. BUSY=1 after k and k+1, and 0 after k+2. SAT=0.
- Continuous ones, GAIN=2, CNT_WIDTH=8, EN=1: Y=1 every cycle. c increments by 1 per cycle to 255, and the clamp occurs on edge 256 → SAT=1 from edge 256 on, c holds at 255.
- Density check, GAIN=2: 10 000 cycles of an LFSR stream with p=0.25 → Y density 0.50 ±0.02, SAT=0.
  - Same stream with p=0.75 → Y density ≥0.99 and SAT=1.
- EN gating, GAIN=4: A=1 at edge k, EN=0 for edges k+1..k+5, then EN=1 → Y=1 after edge k, holds 1 through the stall, then shows 3 more 1s on enabled edges. Total is exactly 4 enabled-cycle ones.
- Reset mid-drain, GAIN=5: A=1 at edge k, RST=1 at edge k+2 → Y=0, BUSY=0 after k+2, and no further 1s with A=0. Also assert RST together with A=1, EN=1 → Y=0 and c=0 after that edge.
- 2×2 independence, GAIN=1 and GAIN=3 builds: drive distinct patterns per element → each Y matches its own per-element model exactly. GAIN=1 build: Y equals A delayed one cycle, with no cross-element coupling.
